// File: rtl/craps_pkg.sv
// rtl/craps_pkg.sv - shared widths and dice/sum constants for the craps roll datapath
// Contents: DIE_W, SUM_W, die range limits, outcome sums, outcome decode helpers.
package craps_pkg;

    localparam int DIE_W = 3;
    localparam int SUM_W = 4;

    localparam logic [DIE_W-1:0] DIE_MIN = 3'd1;
    localparam logic [DIE_W-1:0] DIE_MAX = 3'd6;

    localparam logic [SUM_W-1:0] SUM_SEVEN    = 4'd7;
    localparam logic [SUM_W-1:0] SUM_ELEVEN   = 4'd11;
    localparam logic [SUM_W-1:0] SUM_CRAPS_2  = 4'd2;
    localparam logic [SUM_W-1:0] SUM_CRAPS_3  = 4'd3;
    localparam logic [SUM_W-1:0] SUM_CRAPS_12 = 4'd12;

    function automatic logic is_natural(input logic [SUM_W-1:0] s);
        return (s == SUM_SEVEN) || (s == SUM_ELEVEN);
    endfunction

    function automatic logic is_craps(input logic [SUM_W-1:0] s);
        return (s == SUM_CRAPS_2) || (s == SUM_CRAPS_3) || (s == SUM_CRAPS_12);
    endfunction

endpackage

// File: rtl/die_counter.sv
// rtl/die_counter.sv - mod-6 die counter cycling 1..6 with enable and wrap output
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset (value -> 1)
//   en     in  advance the counter this cycle
//   value  out current face 1..6
//   wrap   out combinational: the counter steps 6 -> 1 at the next edge
module die_counter
    import craps_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [DIE_W-1:0] value,
    output logic             wrap
);

    assign wrap = en && (value == DIE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= DIE_MIN;
        end else if (en) begin
            value <= (value == DIE_MAX) ? DIE_MIN : value + 3'd1;
        end
    end

endmodule

// File: rtl/craps_dice_datapath.sv
// rtl/craps_dice_datapath.sv - free-running dice, captured roll, point register and outcome flags
// Optional feature macro: DICE_LFSR_EN (16-bit Galois LFSR, mask 16'hB400, gates cnt_b stepping)
// Ports:
//   clk_main   in   system clock
//   reset_n    in   asynchronous active-low reset
//   roll       in   capture live dice and evaluate flags
//   sp         in   store registered sum as the point
//   game_clr   in   synchronous clear of point and flags (priority over roll/sp)
//   die1/die2  out  captured dice 1..6
//   sum        out  captured die1+die2
//   point      out  stored point, 0 when none
//   point_vld  out  a point is stored
//   roll_vld   out  pulse: captured values/flags updated this cycle
//   natural, craps, seven_out, eq  out  registered outcome flags
module craps_dice_datapath
    import craps_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk_main,
    input  logic             reset_n,
    input  logic             roll,
    input  logic             sp,
    input  logic             game_clr,
    output logic [DIE_W-1:0] die1,
    output logic [DIE_W-1:0] die2,
    output logic [SUM_W-1:0] sum,
    output logic [SUM_W-1:0] point,
    output logic             point_vld,
    output logic             roll_vld,
    output logic             natural,
    output logic             craps,
    output logic             seven_out,
    output logic             eq
);

    logic [DIE_W-1:0] cnt_a;
    logic [DIE_W-1:0] cnt_b;
    logic             a_wrap;
    logic             b_en;
    logic             b_wrap_unused;
    logic [SUM_W-1:0] live_sum;

`ifdef DICE_LFSR_EN
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [15:0] lfsr;
    logic        a_wrap_unused;

    always_ff @(posedge clk_main or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= SEED_EFF;
        end else if (lfsr[0]) begin
            lfsr <= (lfsr >> 1) ^ LFSR_MASK;
        end else begin
            lfsr <= lfsr >> 1;
        end
    end

    assign b_en          = lfsr[0];
    assign a_wrap_unused = a_wrap;
`else
    logic [15:0] lfsr_seed_unused;

    assign b_en             = a_wrap;
    assign lfsr_seed_unused = LFSR_SEED;
`endif

    die_counter u_cnt_a (
        .clk   (clk_main),
        .rst_n (reset_n),
        .en    (1'b1),
        .value (cnt_a),
        .wrap  (a_wrap)
    );

    die_counter u_cnt_b (
        .clk   (clk_main),
        .rst_n (reset_n),
        .en    (b_en),
        .value (cnt_b),
        .wrap  (b_wrap_unused)
    );

    assign live_sum = SUM_W'(cnt_a) + SUM_W'(cnt_b);

    // Captured roll. Only reset touches it; game_clr leaves the last dice on display.
    always_ff @(posedge clk_main or negedge reset_n) begin
        if (!reset_n) begin
            die1 <= DIE_MIN;
            die2 <= DIE_MIN;
            sum  <= SUM_CRAPS_2;
        end else if (roll && !game_clr) begin
            die1 <= cnt_a;
            die2 <= cnt_b;
            sum  <= live_sum;
        end
    end

    // Point register. sp samples the registered sum, so a simultaneous roll
    // stores the previous roll's sum, and eq/seven_out below see the old point.
    always_ff @(posedge clk_main or negedge reset_n) begin
        if (!reset_n) begin
            point     <= '0;
            point_vld <= 1'b0;
        end else if (game_clr) begin
            point     <= '0;
            point_vld <= 1'b0;
        end else if (sp) begin
            point     <= sum;
            point_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk_main or negedge reset_n) begin
        if (!reset_n) begin
            roll_vld  <= 1'b0;
            natural   <= 1'b0;
            craps     <= 1'b0;
            seven_out <= 1'b0;
            eq        <= 1'b0;
        end else if (game_clr) begin
            roll_vld  <= 1'b0;
            natural   <= 1'b0;
            craps     <= 1'b0;
            seven_out <= 1'b0;
            eq        <= 1'b0;
        end else begin
            roll_vld <= roll;
            if (roll) begin
                natural   <= is_natural(live_sum);
                craps     <= is_craps(live_sum);
                seven_out <= point_vld && (live_sum == SUM_SEVEN);
                eq        <= point_vld && (live_sum == point);
            end
        end
    end

endmodule

// File: tb/tb_craps_dice_datapath.sv
// tb/tb_craps_dice_datapath.sv - directed and randomized checks of craps_dice_datapath against a rule-level model
module tb_craps_dice_datapath;

    logic       clk_main = 1'b0;
    logic       reset_n;
    logic       roll;
    logic       sp;
    logic       game_clr;
    logic [2:0] die1;
    logic [2:0] die2;
    logic [3:0] sum;
    logic [3:0] point;
    logic       point_vld;
    logic       roll_vld;
    logic       natural;
    logic       craps;
    logic       seven_out;
    logic       eq;

    int tests = 0;
    int fails = 0;

    // Model state: n counts rising edges since reset release.
    int n;
    int m_die1, m_die2, m_sum, m_point, m_pv, m_rv;
    int m_nat, m_craps, m_seven, m_eq;

    always #5 clk_main = ~clk_main;

    craps_dice_datapath dut (
        .clk_main  (clk_main),
        .reset_n   (reset_n),
        .roll      (roll),
        .sp        (sp),
        .game_clr  (game_clr),
        .die1      (die1),
        .die2      (die2),
        .sum       (sum),
        .point     (point),
        .point_vld (point_vld),
        .roll_vld  (roll_vld),
        .natural   (natural),
        .craps     (craps),
        .seven_out (seven_out),
        .eq        (eq)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        m_die1 = 1; m_die2 = 1; m_sum = 2; m_point = 0; m_pv = 0; m_rv = 0;
        m_nat = 0; m_craps = 0; m_seven = 0; m_eq = 0;
    endtask

    task automatic check_all();
        chk("die1",      16'(die1),      16'(m_die1));
        chk("die2",      16'(die2),      16'(m_die2));
        chk("sum",       16'(sum),       16'(m_sum));
        chk("point",     16'(point),     16'(m_point));
        chk("point_vld", 16'(point_vld), 16'(m_pv));
        chk("roll_vld",  16'(roll_vld),  16'(m_rv));
        chk("natural",   16'(natural),   16'(m_nat));
        chk("craps",     16'(craps),     16'(m_craps));
        chk("seven_out", 16'(seven_out), 16'(m_seven));
        chk("eq",        16'(eq),        16'(m_eq));
    endtask

    // Game rules applied at one rising edge using the dice visible in cycle n.
    task automatic model_edge(input int r, input int s, input int c);
        int a, b, ls, old_sum;
        a  = (n % 6) + 1;
        b  = ((n / 6) % 6) + 1;
        ls = a + b;
        old_sum = m_sum;
        if (c != 0) begin
            m_point = 0; m_pv = 0; m_rv = 0;
            m_nat = 0; m_craps = 0; m_seven = 0; m_eq = 0;
        end else begin
            if (r != 0) begin
                m_die1  = a;
                m_die2  = b;
                m_sum   = ls;
                m_nat   = (ls == 7 || ls == 11) ? 1 : 0;
                m_craps = (ls == 2 || ls == 3 || ls == 12) ? 1 : 0;
                m_seven = (ls == 7 && m_pv != 0) ? 1 : 0;
                m_eq    = (ls == m_point && m_pv != 0) ? 1 : 0;
            end
            m_rv = r;
            if (s != 0) begin
                m_point = old_sum;
                m_pv    = 1;
            end
        end
        n++;
    endtask

    // Called at a negedge: drive, clock, then check at the following negedge.
    task automatic step(input int r, input int s, input int c);
        roll     = (r != 0);
        sp       = (s != 0);
        game_clr = (c != 0);
        @(posedge clk_main);
        model_edge(r, s, c);
        @(negedge clk_main);
        roll = 1'b0; sp = 1'b0; game_clr = 1'b0;
        check_all();
    endtask

    task automatic roll_at(input int t);
        while ((n % 36) != t) step(0, 0, 0);
        step(1, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0; roll = 1'b0; sp = 1'b0; game_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_main);
        check_all();
        reset_n = 1'b1;

        // Idle after reset: nothing may move on the outputs.
        repeat (40) step(0, 0, 0);

        roll_at(2);
        chk("t2_die1", 16'(die1), 16'd3);
        chk("t2_die2", 16'(die2), 16'd1);
        chk("t2_sum",  16'(sum),  16'd4);
        chk("t2_rv",   16'(roll_vld), 16'd1);
        step(0, 1, 0);
        chk("t2_rv_pulse", 16'(roll_vld), 16'd0);
        chk("t2_point", 16'(point), 16'd4);
        chk("t2_pv",    16'(point_vld), 16'd1);

        roll_at(8);
        chk("t3_sum_a", 16'(sum), 16'd5);
        chk("t3_eq_a",  16'(eq),  16'd0);
        roll_at(14);
        chk("t3_sum_b", 16'(sum), 16'd6);
        roll_at(13);
        chk("t3_sum_c", 16'(sum), 16'd5);
        roll_at(12);
        chk("t3_sum_d", 16'(sum), 16'd4);
        chk("t3_eq_d",  16'(eq),  16'd1);

        step(0, 0, 1);
        roll_at(35);
        chk("t4_sum12", 16'(sum),   16'd12);
        chk("t4_craps", 16'(craps), 16'd1);
        chk("t4_seven", 16'(seven_out), 16'd0);
        roll_at(4);
        chk("t4_sum6", 16'(sum), 16'd6);
        step(0, 1, 0);
        roll_at(9);
        chk("t4_eq", 16'(eq), 16'd1);

        roll_at(20);
        chk("t5_sum7",  16'(sum),       16'd7);
        chk("t5_nat",   16'(natural),   16'd1);
        chk("t5_seven", 16'(seven_out), 16'd1);
        chk("t5_eq",    16'(eq),        16'd0);
        step(0, 0, 1);
        roll_at(20);
        chk("t5_nat_nopt",   16'(natural),   16'd1);
        chk("t5_seven_nopt", 16'(seven_out), 16'd0);

        // Back-to-back rolls keep roll_vld high.
        step(1, 0, 0);
        step(1, 0, 0);
        chk("b2b_rv", 16'(roll_vld), 16'd1);

        // game_clr beats a simultaneous roll and sp.
        step(0, 1, 0);
        step(1, 1, 1);
        chk("t6_point", 16'(point),     16'd0);
        chk("t6_pv",    16'(point_vld), 16'd0);
        chk("t6_rv",    16'(roll_vld),  16'd0);

        // Asynchronous reset right after a roll capture, away from any edge.
        step(0, 1, 0);
        roll = 1'b1;
        @(posedge clk_main);
        #2 reset_n = 1'b0;
        #1;
        roll = 1'b0;
        model_reset();
        check_all();
        @(negedge clk_main);
        reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) == 0) ? 1 : 0,
                 ($urandom_range(0, 4) == 0) ? 1 : 0,
                 ($urandom_range(0, 19) == 0) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
